// File: rtl/dbus_uart_tx.sv
// dbus_uart_tx: D-bus slave with a byte FIFO feeding a UART transmitter (8N1, LSB first).
//
// Register map (word-aligned byte offsets):
//   0x0 DATA   write-only, wdata[7:0] pushed into the TX FIFO; reads 0
//   0x4 STATUS read-only: bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky,
//              cleared by a STATUS read), bits[8:4] FIFO count
//   0x8 DIV    read/write clocks-per-bit in bits[15:0]; values below 2 are stored as 2
//
// Ports:
//   clk    single clock, rising edge
//   rst    synchronous active-high reset
//   ss     slave select
//   bstart one-cycle transfer start strobe (accepted only with ss)
//   ttype  0 = read, 1 = write
//   tsize  0 = byte, 1 = halfword, 2 = word
//   addr   byte offset within the peripheral
//   wdata  write data
//   rdata  read data, valid while bdone is high
//   bdone  completion pulse, one cycle after the accepted strobe
//   tx     UART serial output, idle high
module dbus_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        bstart,
  input  logic        ttype,
  input  logic [1:0]  tsize,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone,
  output logic        tx
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);
  localparam logic [15:0] DivReset = 16'(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     bit_div_q, bit_div_d;   // DIV latched at frame start
  logic [15:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            bdone_q, bdone_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic        xfer, aligned;
  logic        wr_data, rd_status, wr_div, rd_div;
  logic        fifo_full, fifo_empty, push, pop, ovf_evt, busy, bit_end;
  logic [15:0] div_wr;
  logic [31:0] status_w;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  // Bus decode; misaligned or unmapped accesses still complete but touch nothing.
  assign xfer      = ss & bstart;
  assign aligned   = (addr[1:0] == 2'b00);
  assign wr_data   = xfer & aligned & (addr[3:2] == 2'd0) & ttype;
  assign rd_status = xfer & aligned & (addr[3:2] == 2'd1) & ~ttype;
  assign wr_div    = xfer & aligned & (addr[3:2] == 2'd2) & ttype;
  assign rd_div    = xfer & aligned & (addr[3:2] == 2'd2) & ~ttype;

  assign fifo_full  = (count_q == DepthCnt);
  assign fifo_empty = (count_q == 5'd0);
  // Fullness is judged on the pre-pop count, so a simultaneous pop does not make room.
  assign push       = wr_data & ~fifo_full;
  assign ovf_evt    = wr_data & fifo_full;
  assign busy       = (state_q != StIdle);
  assign bit_end    = (clk_cnt_q == bit_div_q - 16'd1);
  assign status_w   = {23'd0, count_q, overflow_q, fifo_empty, fifo_full, busy};

  // A byte-sized DIV write only replaces the low byte.
  assign div_wr = (tsize == 2'd0) ? {div_q[15:8], wdata[7:0]} : wdata[15:0];

  always_comb begin
    div_d = div_q;
    if (wr_div) begin
      div_d = (div_wr < 16'd2) ? 16'd2 : div_wr;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (rd_status) overflow_d = 1'b0;
    if (ovf_evt)   overflow_d = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    if (rd_status) begin
      rdata_d = status_w;
    end else if (rd_div) begin
      rdata_d = {16'd0, div_q};
    end
  end

  assign bdone_d = xfer;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Transmitter next-state logic.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    bit_div_d = bit_div_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_mem[rd_ptr_q];
          bit_div_d = div_q;
          clk_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shreg_q[bit_idx_q];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= DivReset;
      bit_div_q  <= DivReset;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
      bdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_div_q  <= bit_div_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
      bdone_q    <= bdone_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  assign rdata = rdata_q;
  assign bdone = bdone_q;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Scoreboard bench for dbus_uart_tx: a frame-level reference model queues expected bus
// responses and UART frames; independent monitors compare them as the DUT produces them.
module tb_dbus_uart_tx;

  localparam int unsigned ClksPerBit = 16;
  localparam int unsigned Depth      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss = 1'b0, bstart = 1'b0, ttype = 1'b0;
  logic [1:0]  tsize = 2'd0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        bdone, tx;

  dbus_uart_tx #(.CLKS_PER_BIT(ClksPerBit), .FIFO_DEPTH(Depth)) dut (
    .clk(clk), .rst(rst), .ss(ss), .bstart(bstart), .ttype(ttype), .tsize(tsize),
    .addr(addr), .wdata(wdata), .rdata(rdata), .bdone(bdone), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; int unsigned edge_no; } bus_exp_t;
  typedef struct { logic [7:0] b; int unsigned div; int unsigned edge_no; } frame_exp_t;

  bus_exp_t    bus_q[$];
  frame_exp_t  frame_q[$];
  logic [7:0]  fifo_m[$];
  int unsigned edge_cnt = 0;
  int unsigned m_div = ClksPerBit;
  int unsigned next_pop_edge = 0;
  bit          m_ovf = 1'b0;
  bit          abort_frame = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Reference model, evaluated once per rising edge with the inputs that edge samples.
  task automatic model_step();
    int unsigned pre_cnt, div_pre, nd;
    bit          busy;
    logic [31:0] rd;
    bus_exp_t    be;
    frame_exp_t  fe;
    edge_cnt++;
    if (rst) begin
      fifo_m.delete();
      frame_q.delete();
      m_div         = ClksPerBit;
      m_ovf         = 1'b0;
      next_pop_edge = edge_cnt + 1;
      abort_frame   = 1'b1;
      return;
    end
    pre_cnt = fifo_m.size();
    div_pre = m_div;
    busy    = (edge_cnt < next_pop_edge);
    if (ss && bstart) begin
      rd = 32'd0;
      if (addr[1:0] == 2'b00) begin
        case (addr[3:2])
          2'd0: if (ttype) begin
            if (pre_cnt < Depth) fifo_m.push_back(wdata[7:0]);
            else m_ovf = 1'b1;
          end
          2'd1: if (!ttype) begin
            rd = {23'd0, 5'(pre_cnt), m_ovf, pre_cnt == 0, pre_cnt == Depth, busy};
            m_ovf = 1'b0;
          end
          2'd2: if (ttype) begin
            nd = (tsize == 2'd0) ? ((m_div & 32'hFF00) | (wdata & 32'hFF)) : (wdata & 32'hFFFF);
            m_div = (nd < 2) ? 2 : nd;
          end else begin
            rd = div_pre;
          end
          default: ;
        endcase
      end
      be.d = rd;
      be.edge_no = edge_cnt;
      bus_q.push_back(be);
    end
    if (!busy && pre_cnt > 0) begin
      fe.b       = fifo_m.pop_front();
      fe.div     = div_pre;
      fe.edge_no = edge_cnt;
      frame_q.push_back(fe);
      next_pop_edge = edge_cnt + 10 * div_pre + 1;
    end
  endtask

  task automatic bus_monitor();
    bus_exp_t be;
    if (bdone === 1'b1) begin
      n_cmp++;
      if (bus_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_bdone: got bdone=1 at edge %0d, required no response", edge_cnt);
      end else begin
        be = bus_q.pop_front();
        if (rdata !== be.d || edge_cnt != be.edge_no) begin
          n_err++;
          $display("FAIL bus_response: got rdata=%h at edge %0d, required rdata=%h at edge %0d",
                   rdata, edge_cnt, be.d, be.edge_no);
        end
      end
    end
    if (bus_q.size() > 0 && edge_cnt > bus_q[0].edge_no) begin
      be = bus_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL missing_bdone: got bdone=%b at edge %0d, required 1 (rdata=%h)",
               bdone, edge_cnt, be.d);
    end
  endtask

  bit          mon_active = 1'b0;
  bit          mon_bad = 1'b0;
  int unsigned mon_cyc = 0;
  logic        prev_tx = 1'b1;
  frame_exp_t  mon_fr;

  // Checks every frame bit on its first and last clock, plus the frame start time.
  task automatic tx_monitor();
    int unsigned k, c;
    logic [9:0]  bits;
    if (abort_frame) begin
      abort_frame = 1'b0;
      mon_active  = 1'b0;
    end
    if (!mon_active && prev_tx === 1'b1 && tx === 1'b0) begin
      if (frame_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: got start bit at edge %0d, required idle line", edge_cnt);
      end else begin
        mon_fr     = frame_q.pop_front();
        mon_active = 1'b1;
        mon_cyc    = 0;
        mon_bad    = (edge_cnt != mon_fr.edge_no);
      end
    end
    if (mon_active) begin
      k    = mon_cyc / mon_fr.div;
      c    = mon_cyc % mon_fr.div;
      bits = {1'b1, mon_fr.b, 1'b0};
      if ((c == 0 || c == mon_fr.div - 1) && tx !== bits[k]) mon_bad = 1'b1;
      mon_cyc++;
      if (mon_cyc == 10 * mon_fr.div) begin
        mon_active = 1'b0;
        n_cmp++;
        if (mon_bad) begin
          n_err++;
          $display("FAIL uart_frame: got a frame not matching byte %h div %0d start edge %0d",
                   mon_fr.b, mon_fr.div, mon_fr.edge_no);
        end
      end
    end
    prev_tx = tx;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    bus_monitor();
    tx_monitor();
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic t, input logic [1:0] sz, input logic [3:0] a,
                     input logic [31:0] d);
    ss = 1'b1; bstart = 1'b1; ttype = t; tsize = sz; addr = a; wdata = d;
    cycles(1);
    ss = 1'b0; bstart = 1'b0; ttype = 1'b0; wdata = 32'd0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int i = 0;
    while ((frame_q.size() != 0 || fifo_m.size() != 0 || mon_active ||
            edge_cnt < next_pop_edge) && i < max_cycles) begin
      cycles(1);
      i++;
    end
    n_cmp++;
    if (i >= max_cycles) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d frames pending after %0d cycles, required 0",
               frame_q.size() + fifo_m.size(), max_cycles);
    end
  endtask

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    int          r;
    // Reset, with a write strobe during reset that must be ignored.
    cycles(2);
    bus(1'b1, 2'd2, 4'h0, 32'hA5);
    rst = 1'b0;
    cycles(1);

    // Idle register reads, then misaligned and unmapped accesses.
    bus(1'b0, 2'd2, 4'h4, 32'd0);
    bus(1'b0, 2'd2, 4'h0, 32'd0);
    bus(1'b0, 2'd2, 4'h8, 32'd0);
    bus(1'b1, 2'd2, 4'h2, 32'h11);
    bus(1'b1, 2'd2, 4'hC, 32'h22);
    bus(1'b0, 2'd2, 4'h2, 32'd0);
    bus(1'b0, 2'd2, 4'hC, 32'd0);
    bus(1'b1, 2'd2, 4'h4, 32'hFFFF);
    bus(1'b0, 2'd2, 4'h4, 32'd0);

    // DIV clamping and byte-lane writes.
    bus(1'b1, 2'd2, 4'h8, 32'd0);
    bus(1'b0, 2'd2, 4'h8, 32'd0);
    bus(1'b1, 2'd1, 4'h8, 32'hABCD1234);
    bus(1'b0, 2'd2, 4'h8, 32'd0);
    bus(1'b1, 2'd0, 4'h8, 32'hFFFF0001);
    bus(1'b0, 2'd2, 4'h8, 32'd0);
    bus(1'b1, 2'd2, 4'h8, 32'd5);
    bus(1'b1, 2'd0, 4'h8, 32'd0);
    bus(1'b0, 2'd2, 4'h8, 32'd0);

    // Single 0x55 frame at DIV 4.
    bus(1'b1, 2'd2, 4'h8, 32'd4);
    bus(1'b1, 2'd0, 4'h0, 32'h55);
    wait_drain(200);
    bus(1'b0, 2'd2, 4'h4, 32'd0);

    // Fill the FIFO back-to-back at DIV 16, overflow, sticky clear on read.
    bus(1'b1, 2'd2, 4'h8, 32'd16);
    for (int i = 0; i < 10; i++) bus(1'b1, 2'd0, 4'h0, $urandom);
    bus(1'b0, 2'd2, 4'h4, 32'd0);
    bus(1'b0, 2'd2, 4'h4, 32'd0);
    wait_drain(3000);

    // DIV change mid-frame applies from the next frame.
    bus(1'b1, 2'd2, 4'h0, $urandom);
    bus(1'b1, 2'd2, 4'h0, $urandom);
    cycles(40);
    bus(1'b1, 2'd2, 4'h8, 32'd8);
    wait_drain(1000);

    // Randomized traffic with small DIV values so the FIFO regularly fills.
    bus(1'b1, 2'd2, 4'h8, 32'd3);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        cycles($urandom_range(1, 4));
      end else if (r == 2) begin
        if ($urandom_range(0, 1) == 0) ss = 1'b1;
        else bstart = 1'b1;
        addr = 4'h4;
        cycles(1);
        ss = 1'b0;
        bstart = 1'b0;
      end else begin
        r = $urandom_range(0, 7);
        a = (r < 3) ? 4'h0 : (r == 3) ? 4'h4 : (r == 4) ? 4'h8 : 4'($urandom);
        d = $urandom;
        if (a == 4'h8) d[15:0] = 16'($urandom_range(0, 6));
        bus(1'($urandom), 2'($urandom_range(0, 3)), a, d);
      end
    end
    wait_drain(5000);

    // Reset during data bit 3 with three bytes still queued.
    bus(1'b1, 2'd2, 4'h8, 32'd8);
    for (int i = 0; i < 4; i++) bus(1'b1, 2'd0, 4'h0, $urandom);
    cycles(32);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL tx_after_reset: got %b, required 1", tx);
    end
    @(posedge clk);
    #1;
    bus(1'b0, 2'd2, 4'h4, 32'd0);
    bus(1'b0, 2'd2, 4'h8, 32'd0);
    cycles(300);

    n_cmp++;
    if (bus_q.size() != 0 || frame_q.size() != 0 || mon_active) begin
      n_err++;
      $display("FAIL end_pending: got %0d responses and %0d frames outstanding, required 0",
               bus_q.size(), frame_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dbus_uart_tx.md
DBUS_UART_TX -- requirements
Module: dbus_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, reset value of the DIV register (clocks per UART bit).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ss  input  1  slave select from D-bus interconnect.
REQ-006 SHALL have port bstart  input  1  one-cycle transfer start strobe.
REQ-007 SHALL have port ttype  input  1  0 = READ, 1 = WRITE.
REQ-008 SHALL have port tsize  input  2  0 = BYTE, 1 = HALFWORD, 2 = WORD.
REQ-009 SHALL have port addr  input  4  byte offset within the peripheral.
REQ-010 SHALL have port wdata  input  32  write data.
REQ-011 SHALL have port rdata  output  32  read data, valid while bdone = 1.
REQ-012 SHALL have port bdone  output  1  one-cycle transfer completion pulse.
REQ-013 SHALL have port tx  output  1  UART serial output, idle high.

Function
REQ-014 SHALL accept a transfer in cycle N only when ss = 1 and bstart = 1; bdone SHALL be 1 in cycle N+1 only, 0 otherwise.
REQ-015 SHALL provide registers: 0x0 DATA (write only, reads 0), 0x4 STATUS (read only), 0x8 DIV (read/write, bits[15:0]; bits[31:16] read 0).
REQ-016 SHALL ignore accesses with addr[1:0] != 0 or unmapped offsets (no state change, rdata = 0); bdone still pulses.
REQ-017 SHALL use wdata[7:0] for DATA and wdata[15:0] for DIV regardless of tsize; a BYTE write to DIV updates bits[7:0] only.
REQ-018 DATA write SHALL push wdata[7:0] into the FIFO in cycle N if count < FIFO_DEPTH, else drop the byte and set sticky STATUS.overflow.
REQ-019 STATUS SHALL be: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow, bits[8:4] FIFO count, others 0.
REQ-020 STATUS read SHALL return the value sampled in cycle N and clear overflow at cycle N+1, unless an overflow occurs in cycle N (then overflow remains 1).
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged; fullness for push acceptance SHALL be judged on the pre-pop count.
REQ-022 DIV writes of values < 2 SHALL store 2.
REQ-023 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-024 IDLE: tx = 1; if FIFO non-empty, pop head, latch the byte and the current DIV, go START.
REQ-025 START: tx = 0 for DIV clocks, then go DATA with bit index 0.
REQ-026 DATA: drive bit[index] (LSB first) for DIV clocks each; after bit 7 go STOP.
REQ-027 STOP: tx = 1 for DIV clocks, then go IDLE; one frame = 10 x DIV clocks, and back-to-back frames SHALL add at most one IDLE cycle.
REQ-028 DIV changes during a frame SHALL take effect only at the next frame start.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.

Reset
REQ-030 With rst = 1 at a clock edge: FSM IDLE, tx = 1, FIFO empty (count 0), overflow 0, DIV = CLKS_PER_BIT, bdone = 0, rdata = 0.
REQ-031 Reset mid-frame SHALL abort the frame immediately (tx = 1 next cycle) and discard FIFO contents; transfers with bstart during rst are ignored.

Verification
REQ-032 Write DATA 0x55, DIV = 4 -> tx: 0 for 4 clk, then 1,0,1,0,1,0,1,0 (4 clk each), 1 for 4 clk; frame 40 clk; STATUS then reads 0x004.
REQ-033 With DIV = 16, write 9 bytes back-to-back (FIFO_DEPTH 8) -> first byte popped into the FSM, 8 stored, none dropped; a 10th write while full sets overflow; STATUS read returns bit3 = 1, next read bit3 = 0.
REQ-034 Read STATUS at idle after reset -> bdone exactly one cycle after bstart, rdata = 0x004; read DATA -> 0; read 0x8 -> 0x0010.
REQ-035 Write DIV = 0 -> reads back 2; write DIV = 8 mid-frame -> current frame keeps old DIV, next frame uses 8 clk/bit.
REQ-036 Assert rst during DATA bit 3 with 3 bytes queued -> tx = 1 next cycle, STATUS = 0x004, DIV = CLKS_PER_BIT, no further frames.
REQ-037 Write to addr 0x2 and 0xC -> bdone pulses, no FIFO push, rdata = 0.
